code_entry: RTL

Sequential keypad code-entry controller for the door-lock datapath. It collects four BCD digits from the keypad and presents them to the 4-digit comparator. On the enter key it samples the comparator's equal result, then drives a timed unlock pulse or counts a failed attempt, raising a timed alarm lockout after too many failures.

---
 rtl/code_entry_pkg.sv | 16 +
 rtl/code_entry_hold_timer.sv | 33 +++
 rtl/code_entry.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/code_entry_pkg.sv
// Shared types and constants for the keypad code-entry controller.
package code_entry_pkg;

  typedef enum logic [1:0] {
    StEntry,
    StCheck,
    StUnlocked,
    StLockout
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/code_entry_hold_timer.sv
// Loadable saturating down-counter; zero_o flags expiry of the hold period.
module code_entry_hold_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/code_entry.sv
// Keypad code-entry controller: collects four BCD digits, checks them against the
// comparator on enter, then drives a timed unlock pulse or a timed alarm lockout.
module code_entry
  import code_entry_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       equal_i,
  output logic [3:0] bcd_0_o,
  output logic [3:0] bcd_1_o,
  output logic [3:0] bcd_2_o,
  output logic [3:0] bcd_3_o,
  output logic [2:0] count_o,
  output logic       unlock_o,
  output logic       alarm_o,
  output logic       busy_o
);

  localparam int unsigned AttW   = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TmrMax = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [TmrW-1:0] UnlockLoad  = TmrW'(UNLOCK_CYCLES - 1);
  localparam logic [TmrW-1:0] LockoutLoad = TmrW'(LOCKOUT_CYCLES - 1);

  state_e          state_d, state_q;
  logic [3:0]      digits_d [NUM_DIGITS];
  logic [3:0]      digits_q [NUM_DIGITS];
  logic [2:0]      count_d, count_q;
  logic [AttW-1:0] attempts_d, attempts_q;
  logic            key_valid_q;
  logic            press;
  logic            tmr_load;
  logic [TmrW-1:0] tmr_value;
  logic            tmr_zero;
  logic            unlock_q, alarm_q, busy_q;

  // Rising edge of the key-down level; key_valid_q resets high so a key held
  // through reset release is not taken as a press.
  assign press = key_valid_i & ~key_valid_q;

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    count_d    = count_q;
    attempts_d = attempts_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    unique case (state_q)
      StEntry: begin
        if (press) begin
          if (key_code_i <= 4'd9) begin
            if (count_q < 3'(NUM_DIGITS)) begin
              digits_d[count_q[1:0]] = key_code_i;
              count_d                = count_q + 3'd1;
            end
          end else if (key_code_i == KEY_CLEAR) begin
            digits_d = '{default: '0};
            count_d  = '0;
          end else if (key_code_i == KEY_ENTER && count_q == 3'(NUM_DIGITS)) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        digits_d = '{default: '0};
        count_d  = '0;
        if (equal_i) begin
          state_d    = StUnlocked;
          attempts_d = '0;
          tmr_load   = 1'b1;
          tmr_value  = UnlockLoad;
        end else if ((32'(attempts_q) + 32'd1) < MAX_ATTEMPTS) begin
          state_d    = StEntry;
          attempts_d = attempts_q + 1'b1;
        end else begin
          state_d    = StLockout;
          attempts_d = '0;
          tmr_load   = 1'b1;
          tmr_value  = LockoutLoad;
        end
      end
      StUnlocked, StLockout: begin
        if (tmr_zero) begin
          state_d = StEntry;
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StEntry;
      digits_q    <= '{default: '0};
      count_q     <= '0;
      attempts_q  <= '0;
      key_valid_q <= 1'b1;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      attempts_q  <= attempts_d;
      key_valid_q <= key_valid_i;
      unlock_q    <= (state_d == StUnlocked);
      alarm_q     <= (state_d == StLockout);
      busy_q      <= (state_d != StEntry);
    end
  end

  code_entry_hold_timer #(
    .Width(TmrW)
  ) u_hold_timer (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .load_i (tmr_load),
    .value_i(tmr_value),
    .zero_o (tmr_zero)
  );

  assign bcd_0_o  = digits_q[0];
  assign bcd_1_o  = digits_q[1];
  assign bcd_2_o  = digits_q[2];
  assign bcd_3_o  = digits_q[3];
  assign count_o  = count_q;
  assign unlock_o = unlock_q;
  assign alarm_o  = alarm_q;
  assign busy_o   = busy_q;

endmodule
